// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot row drive, 2-flop column sync, debounce, one new_num per press.
// Define KEYPAD_REPEAT_EN to re-pulse new_num every REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
    parameter int ROW_DWELL       = 3,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int RELEASE_CYCLES  = 20
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_CYCLES = 500
`endif
) (
    input  logic       fsm_clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] num,
    output logic       new_num,
    output logic       idle,
    output logic       pressed
);

    localparam logic [2:0] S_SCAN     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_FIRE     = 3'd2;
    localparam logic [2:0] S_HELD     = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;
    localparam logic [2:0] S_REPEAT   = 3'd5;

    localparam int DW_W = $clog2(ROW_DWELL + 1);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RL_W = $clog2(RELEASE_CYCLES + 1);

    localparam logic [DW_W-1:0] DW_LAST = DW_W'(ROW_DWELL - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RL_W-1:0] RL_LAST = RL_W'(RELEASE_CYCLES - 1);
    localparam logic [RL_W-1:0] RL_MAX  = RL_W'(RELEASE_CYCLES);

    // Nibble (row*4 + col) holds the keycap legend for that crossing.
    localparam logic [63:0] KEY_MAP = {4'hD, 4'hF, 4'h0, 4'hE,
                                       4'hC, 4'h9, 4'h8, 4'h7,
                                       4'hB, 4'h6, 4'h5, 4'h4,
                                       4'hA, 4'h3, 4'h2, 4'h1};

    logic [2:0]      state;
    logic [3:0]      sync1;
    logic [3:0]      scols;
    logic [3:0]      lat_col;
    logic [DW_W-1:0] dwell_cnt;
    logic [DB_W-1:0] deb_cnt;
    logic [RL_W-1:0] rel_cnt;
    logic            scols_onehot;

`ifdef KEYPAD_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
    logic [RP_W-1:0] rep_cnt;
`endif

    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        case (v)
            4'b0010: oh_idx = 2'd1;
            4'b0100: oh_idx = 2'd2;
            4'b1000: oh_idx = 2'd3;
            default: oh_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] idx;
        idx      = {oh_idx(r), oh_idx(c)};
        key_code = KEY_MAP[idx*4 +: 4];
    endfunction

    assign scols_onehot = (scols != 4'b0) && ((scols & (scols - 4'd1)) == 4'b0);

    assign new_num = (state == S_FIRE) || (state == S_REPEAT);
    assign idle    = (state == S_SCAN);
    assign pressed = (state == S_HELD) || (state == S_REPEAT);

    always_ff @(posedge fsm_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SCAN;
            sync1     <= 4'b0;
            scols     <= 4'b0;
            lat_col   <= 4'b0;
            rows      <= 4'b0001;
            num       <= 4'h0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            sync1 <= cols;
            scols <= sync1;
            case (state)
                S_SCAN: begin
                    // scols lags rows by two cycles, so only the last dwell cycle reflects this row.
                    if (dwell_cnt == DW_LAST) begin
                        dwell_cnt <= '0;
                        if (scols_onehot) begin
                            lat_col <= scols;
                            deb_cnt <= '0;
                            state   <= S_DEBOUNCE;
                        end else begin
                            rows <= {rows[2:0], rows[3]};
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (scols == lat_col) begin
                        if (deb_cnt != DB_MAX) deb_cnt <= deb_cnt + 1'b1;
                        if (deb_cnt == DB_LAST) begin
                            num   <= key_code(rows, lat_col);
                            state <= S_FIRE;
                        end
                    end else begin
                        deb_cnt <= '0;
                        state   <= S_SCAN;
                    end
                end
                S_FIRE: begin
                    deb_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt <= RP_W'(1);
`endif
                    state   <= S_HELD;
                end
                S_HELD: begin
                    if (scols == 4'b0) begin
                        rel_cnt <= '0;
                        state   <= S_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_cnt == RP_LAST) begin
                        state <= S_REPEAT;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                S_REPEAT: begin
`ifdef KEYPAD_REPEAT_EN
                    // Restarting at 1 makes the pulse spacing exactly REPEAT_CYCLES.
                    rep_cnt <= RP_W'(1);
`endif
                    rel_cnt <= '0;
                    state   <= (scols == 4'b0) ? S_RELEASE : S_HELD;
                end
                S_RELEASE: begin
                    if (scols == 4'b0) begin
                        if (rel_cnt != RL_MAX) rel_cnt <= rel_cnt + 1'b1;
                        if (rel_cnt == RL_LAST) begin
                            rel_cnt   <= '0;
                            dwell_cnt <= '0;
                            rows      <= {rows[2:0], rows[3]};
                            state     <= S_SCAN;
                        end
                    end else begin
                        rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt <= RP_W'(1);
`endif
                        state   <= S_HELD;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner; a keypad model closes the row/column loop.
// Expected key codes, pulse counts and scan order come from a key table and simple arithmetic.
module tb_keypad_scanner;

    localparam int DEBOUNCE = 20;

    logic       fsm_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] num;
    logic       new_num;
    logic       idle;
    logic       pressed;

    // Keypad model: the switch at (key_row, any bit of key_cols) closes while contact is high.
    logic       contact  = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [3:0] key_cols = 4'b0;

    assign cols = (contact && rows[key_row]) ? key_cols : 4'b0;

    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;
    int         pressed_cyc = 0;
    logic [3:0] last_num = 4'h0;

    keypad_scanner dut (
        .fsm_clk (fsm_clk),
        .reset   (reset),
        .cols    (cols),
        .rows    (rows),
        .num     (num),
        .new_num (new_num),
        .idle    (idle),
        .pressed (pressed)
    );

    always #5 fsm_clk = ~fsm_clk;

    always @(posedge fsm_clk) cyc <= cyc + 1;

    always @(negedge fsm_clk) begin
        if (new_num) begin
            pulse_cnt      = pulse_cnt + 1;
            last_num       = num;
            last_pulse_cyc = cyc;
        end
        if (pressed) pressed_cyc = pressed_cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fsm_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!idle && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic set_key(input int r, input int c);
        key_row  = 2'(r);
        key_cols = 4'(1 << c);
    endtask

    initial begin
        int p0;
        int stable_start;
        int idle_low;
        int k;
        int r;
        int c;
        int hold;
        logic [3:0] seen;

        #23;
        check("rst_rows", 32'(rows), 32'h1);
        check("rst_num", 32'(num), 32'h0);
        check("rst_new_num", 32'(new_num), 32'h0);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_pressed", 32'(pressed), 32'h0);

        // Idle scan: after k edges the driven row is (k / dwell) mod 4.
        @(posedge fsm_clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check("scan_rows", 32'(rows), 32'(4'b0001 << ((i / 3) % 4)));
            check("scan_idle", 32'(idle), 32'h1);
            tick(1);
        end

        // Clean press of key 6 held for 100 cycles.
        p0 = pulse_cnt;
        set_key(1, 2);
        contact = 1'b1;
        tick(100);
        check("clean_pressed", 32'(pressed), 32'h1);
        check("clean_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("clean_num", 32'(last_num), 32'(key_map[1*4+2]));
        check("clean_num_hold", 32'(num), 32'(key_map[1*4+2]));
        contact = 1'b0;
        wait_idle("clean_release_idle", 100);
        check("clean_pulses_after", 32'(pulse_cnt - p0), 32'd1);

        // Bouncing contact, then stable: a single pulse only after a full stable window.
        p0 = pulse_cnt;
        set_key(2, 1);
        for (int i = 0; i < 12; i++) begin
            contact = (i % 2 == 0);
            tick(5);
        end
        check("bounce_no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
        contact = 1'b1;
        stable_start = cyc;
        tick(60);
        check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("bounce_stable_wait", 32'((last_pulse_cyc - stable_start) >= DEBOUNCE), 32'd1);
        check("bounce_num", 32'(last_num), 32'(key_map[2*4+1]));
        contact = 1'b0;
        wait_idle("bounce_release_idle", 100);

        // Release glitch: a 2-cycle reclosure must not restart the press or emit a pulse.
        p0 = pulse_cnt;
        set_key(0, 1);
        contact = 1'b1;
        tick(60);
        check("glitch_first_pulse", 32'(pulse_cnt - p0), 32'd1);
        contact = 1'b0;
        tick(10);
        contact = 1'b1;
        tick(2);
        contact = 1'b0;
        tick(20);
        check("glitch_still_busy", 32'(idle), 32'h0);
        tick(5);
        check("glitch_idle_after_quiet", 32'(idle), 32'h1);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("glitch_num", 32'(num), 32'(key_map[0*4+1]));

        // Two keys in the same row read as no key: scanning carries on.
        p0 = pulse_cnt;
        key_row  = 2'd2;
        key_cols = 4'b0011;
        contact  = 1'b1;
        idle_low = 0;
        seen     = 4'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (!idle) idle_low++;
            seen = seen | rows;
        end
        contact = 1'b0;
        check("multi_idle_low", 32'(idle_low), 32'd0);
        check("multi_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("multi_rows_seen", 32'(seen), 32'hF);

        // Reset part-way through debounce: no pulse, outputs back to reset values.
        p0 = pulse_cnt;
        set_key(3, 2);
        contact = 1'b1;
        k = 0;
        while (idle && k < 40) begin
            tick(1);
            k++;
        end
        check("rstdb_entered", 32'(idle), 32'h0);
        tick(15);
        check("rstdb_no_pulse_yet", 32'(pulse_cnt - p0), 32'd0);
        reset = 1'b0;
        #2;
        check("rstdb_rows", 32'(rows), 32'h1);
        check("rstdb_num", 32'(num), 32'h0);
        check("rstdb_new_num", 32'(new_num), 32'h0);
        check("rstdb_idle", 32'(idle), 32'h1);
        contact = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(40);
        check("rstdb_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("rstdb_num_after", 32'(num), 32'h0);

        // Random single presses with random hold and gap times.
        for (int i = 0; i < 8; i++) begin
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            hold = $urandom_range(50, 120);
            p0   = pulse_cnt;
            pressed_cyc = 0;
            set_key(r, c);
            contact = 1'b1;
            tick(hold);
            contact = 1'b0;
            wait_idle("rand_idle", 100);
            check("rand_pulses", 32'(pulse_cnt - p0), 32'd1);
            check("rand_num", 32'(last_num), 32'(key_map[r*4+c]));
            check("rand_pressed_seen", 32'(pressed_cyc > 0), 32'd1);
            tick($urandom_range(0, 10));
        end

        // Long hold of key A.
        p0 = pulse_cnt;
        set_key(0, 3);
        contact = 1'b1;
`ifdef KEYPAD_REPEAT_EN
        tick(1200);
        contact = 1'b0;
        wait_idle("long_idle", 100);
        // Fire plus repeats at +500 and +1000 cycles all land inside a 1200-cycle hold.
        check("long_pulses", 32'(pulse_cnt - p0), 32'd3);
`else
        tick(600);
        contact = 1'b0;
        wait_idle("long_idle", 100);
        check("long_pulses", 32'(pulse_cnt - p0), 32'd1);
`endif
        check("long_num", 32'(last_num), 32'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
